// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ requesters.
// A grant is held for up to MAX_BURST accepted beats, and no write is issued while the FIFO is full.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_srst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata,
    output logic [NUM_REQ-1:0]            o_ack,
    input  logic                          i_fifo_full,
    output logic                          o_fifo_we,
    output logic [DATA_WIDTH-1:0]         o_fifo_wdata,
    output logic [ID_WIDTH-1:0]           o_grant_id,
    output logic                          o_busy
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [ID_WIDTH-1:0] owner_reg, owner_next;
    logic [ID_WIDTH-1:0] last_reg, last_next;
    logic [CNT_W-1:0]    beat_cnt_reg, beat_cnt_next;

    logic [DATA_WIDTH-1:0] slice [NUM_REQ];
    logic                  req_owner;
    logic                  beat;
    logic                  burst_done;
    logic                  release_grant;
    logic                  pick_valid;
    logic [ID_WIDTH-1:0]   pick_id;
    logic [ID_WIDTH-1:0]   cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign slice[gi] = i_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign o_ack[gi] = beat && (owner_reg == ID_WIDTH'(gi));
        end
    endgenerate

    // Reset gates every write strobe so an abandoned burst never leaks a beat.
    assign req_owner     = i_req[owner_reg];
    assign beat          = (state_reg == GRANT) && req_owner && !i_fifo_full && !i_srst;
    assign burst_done    = beat && (beat_cnt_reg == CNT_W'(MAX_BURST - 1));
    assign release_grant = burst_done || !req_owner;

    assign o_fifo_we    = beat;
    assign o_fifo_wdata = slice[owner_reg];
    assign o_grant_id   = owner_reg;
    assign o_busy       = (state_reg == GRANT) && !i_srst;

    // Scan from the farthest offset inward so the nearest request after last_reg wins;
    // last_reg itself is reached at offset NUM_REQ and therefore has lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = ID_WIDTH'((int'(last_reg) + off) % NUM_REQ);
            if (i_req[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        last_next     = last_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next    = GRANT;
                    owner_next    = pick_id;
                    last_next     = pick_id;
                    beat_cnt_next = '0;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    beat_cnt_next = '0;
                    if (pick_valid) begin
                        owner_next = pick_id;
                        last_next  = pick_id;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (beat) begin
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_reg    <= IDLE;
            owner_reg    <= '0;
            last_reg     <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            last_reg     <= last_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the write port of a `dual_clock_fifo_wrapper` instance among `NUM_REQ` requesters in the FIFO's write-clock domain. Each requester presents data with a level request and holds it until acknowledged. The arbiter locks a grant for bursts of up to `MAX_BURST` beats and never writes while the FIFO reports full. It drives `i_we`/`i_wdata` of the FIFO directly, so the FIFO's own overflow check is never exercised.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: data width; must equal the FIFO `DATA_WIDTH`.
- `MAX_BURST`, 4: maximum beats accepted per grant before rotation, 1..256.
- `ID_WIDTH`, `$clog2(NUM_REQ)`: width of the grant ID.

Ports:
- `i_clk`  in  1  single clock, equal to the FIFO write clock.
- `i_srst`  in  1  synchronous, active-high reset.
- `i_req`  in  `NUM_REQ`  bit k: requester k has a valid beat on its data slice.
- `i_wdata`  in  `NUM_REQ*DATA_WIDTH`  requester k data at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `o_ack`  out  `NUM_REQ`  one-hot or zero; bit k set means requester k's beat is written this cycle.
- `i_fifo_full`  in  1  FIFO `o_full`.
- `o_fifo_we`  out  1  to FIFO `i_we`.
- `o_fifo_wdata`  out  `DATA_WIDTH`  to FIFO `i_wdata`.
- `o_grant_id`  out  `ID_WIDTH`  current or last owner index (registered).
- `o_busy`  out  1  high while in GRANT.

## Operation

Registered state:
- `state`: IDLE or GRANT.
- `owner`: `ID_WIDTH` bits.
- `last`: round-robin pointer.
- `beat_cnt`: 0..`MAX_BURST-1`.

Round-robin pick:
- Search `i_req` starting at index `last+1` and wrap modulo `NUM_REQ`.
- The requester at `last` is considered last.

IDLE:
- If any `i_req` bit is set: `owner` takes the pick, `last` takes the pick, `beat_cnt` is 0, and `state` goes to GRANT.
- Otherwise remain in IDLE.

GRANT, combinational outputs:
- `beat = i_req[owner] & ~i_fifo_full`.
- `o_fifo_we = beat`.
- `o_ack[owner] = beat`; all other `o_ack` bits are 0.
- `o_fifo_wdata` = owner's data slice, always driven.

GRANT, release conditions. Release occurs on:
- `beat & (beat_cnt == MAX_BURST-1)`, or
- `~i_req[owner]`.

GRANT, on release:
- If any `i_req` bit is set: the round-robin pick becomes the new `owner` and `last`, `beat_cnt` is 0, and the block stays in GRANT.
- The released owner may re-win only if no other requester is pending.
- If no `i_req` bit is set: go to IDLE.

GRANT, no release:
- `beat` increments `beat_cnt`.
- A full stall holds `owner` and `beat_cnt` unchanged.
- There is no stall timeout.

General rules:
- Requester protocol: once `i_req[k]` is raised, its data is held stable until `o_ack[k]`. Dropping `i_req` before acknowledgement is legal; that beat is not written.
- `beat_cnt` counts accepted beats only and never wraps past `MAX_BURST-1`.
- With `MAX_BURST=1`, the grant rotates after every beat.

## Timing

- Edge n starts cycle n; all registers update on the rising edge of `i_clk`.
- Arbitration latency from IDLE is 1 cycle: `i_req[k]` first high in cycle n gives `o_ack[k]`/`o_fifo_we` in cycle n+1, if not full.
- Handover inside GRANT has no bubble: the last beat of burst A in cycle n is followed by the first beat of owner B in cycle n+1.
- An owner that drops `i_req` costs one idle cycle (the release cycle) before the next owner writes.
- The full path is combinational: `i_fifo_full` high in cycle n forces `o_fifo_we=0` and `o_ack=0` in cycle n.
- Reset:
  - While `i_srst` is high, `o_fifo_we`, `o_ack` and `o_busy` are forced to 0 combinationally.
  - After the reset edge: `state`=IDLE, `owner`=0, `o_grant_id`=0, `beat_cnt`=0, `last`=`NUM_REQ-1`, so requester 0 wins first.
- Reset mid-burst: the partial burst is abandoned, no write occurs in the reset cycle, and arbitration restarts from requester 0.

## Test plan

- **Reset:** `i_srst` high 2 cycles with `i_req`=4'b1111 -> `o_fifo_we`=0, `o_ack`=0, `o_busy`=0, `o_grant_id`=0; first cycle after release `o_busy`=0, next cycle `o_ack`=4'b0001.
- **Single requester:** requester 1 streams 0x01..0x0A continuously, `MAX_BURST`=4 -> FIFO receives 0x01..0x0A in order, 10 consecutive `o_fifo_we` cycles after the 1-cycle arbitration, `o_grant_id` stays 1.
- **Fairness:** all 4 requesters continuously high -> owners 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0... with no idle write cycles.
- **Backpressure:** `i_fifo_full` high for 5 cycles after beat 2 of requester 2's burst -> `o_fifo_we`/`o_ack`=0 for exactly those 5 cycles, then beats 3 and 4 of requester 2 are written before rotation.
- **Early drop:** requester 0 drops `i_req` after 2 beats while requester 3 is pending -> 1 idle cycle, then requester 3 is granted; the next pick after 3 is 0.
- **Reset mid-burst:** `i_srst` pulsed during beat 3 of a requester-2 burst -> no write in the reset cycle, IDLE next cycle, requester 0 granted first if requesting.
